// File: rtl/alu_operand_sequencer_if.sv
// Board/ALU-side signal bundle for alu_operand_sequencer: switches, button and
// ALU result in; ALU operands, held result and status out.
interface alu_operand_sequencer_if;
    logic [3:0] i_sw;
    logic [2:0] i_op_sw;
    logic       i_btn;
    logic [4:0] i_alu_result;
    logic [3:0] o_a;
    logic [3:0] o_b;
    logic [2:0] o_op;
    logic [4:0] o_result;
    logic       o_done;
    logic       o_op_err;
    logic [2:0] o_state;

    modport slave (
        input  i_sw, i_op_sw, i_btn, i_alu_result,
        output o_a, o_b, o_op, o_result, o_done, o_op_err, o_state
    );

    modport master (
        output i_sw, i_op_sw, i_btn, i_alu_result,
        input  o_a, o_b, o_op, o_result, o_done, o_op_err, o_state
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Loads A, B and opcode from shared switches on button presses, then captures the ALU result.
// Optional macro DEBOUNCE_EN adds a DEBOUNCE_CYCLES stable-high filter on the button.
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    alu_operand_sequencer_if.slave        bus
);
    typedef enum logic [2:0] {
        S_A    = 3'b000,
        S_B    = 3'b001,
        S_OP   = 3'b010,
        S_EXEC = 3'b011,
        S_SHOW = 3'b100
    } state_t;

    state_t     r_state, w_stateNext;
    logic [3:0] r_a, r_b, w_aNext, w_bNext;
    logic [2:0] r_op, w_opNext;
    logic [4:0] r_result, w_resultNext;
    logic       r_done, w_doneNext;
    logic       r_opErr, w_opErrNext;

    logic r_sync1, r_sync2, r_btnPrev;
    logic w_btnLevel, w_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CountW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CountW-1:0] r_dbCount;
    logic              r_dbLevel;

    // Level rises only after DEBOUNCE_CYCLES consecutive high samples; any low sample restarts.
    always_ff @(posedge clk) begin
        if (rst || !r_sync2) begin
            r_dbCount <= '0;
            r_dbLevel <= 1'b0;
        end else if (!r_dbLevel) begin
            if (r_dbCount == CountW'(DEBOUNCE_CYCLES - 1))
                r_dbLevel <= 1'b1;
            else
                r_dbCount <= r_dbCount + CountW'(1);
        end
    end

    assign w_btnLevel = r_dbLevel;
`else
    if (DEBOUNCE_CYCLES >= 0) begin : gNoDebounce
        assign w_btnLevel = r_sync2;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_btnPrev <= 1'b0;
        else
            r_btnPrev <= w_btnLevel;
    end

    assign w_press = w_btnLevel & ~r_btnPrev;

    always_comb begin
        w_stateNext  = r_state;
        w_aNext      = r_a;
        w_bNext      = r_b;
        w_opNext     = r_op;
        w_resultNext = r_result;
        w_doneNext   = r_done;
        w_opErrNext  = r_opErr;
        case (r_state)
            S_A: if (w_press) begin
                w_aNext     = bus.i_sw;
                w_stateNext = S_B;
            end
            S_B: if (w_press) begin
                w_bNext     = bus.i_sw;
                w_stateNext = S_OP;
            end
            S_OP: if (w_press) begin
                w_opNext    = bus.i_op_sw;
                w_opErrNext = (bus.i_op_sw > 3'b001);
                w_stateNext = S_EXEC;
            end
            S_EXEC: begin
                w_resultNext = bus.i_alu_result;
                w_doneNext   = 1'b1;
                w_stateNext  = S_SHOW;
            end
            S_SHOW: if (w_press) begin
                w_aNext      = 4'd0;
                w_bNext      = 4'd0;
                w_opNext     = 3'd0;
                w_resultNext = 5'd0;
                w_doneNext   = 1'b0;
                w_opErrNext  = 1'b0;
                w_stateNext  = S_A;
            end
            // Unused codes recover to a cleared S_A.
            default: begin
                w_aNext      = 4'd0;
                w_bNext      = 4'd0;
                w_opNext     = 3'd0;
                w_resultNext = 5'd0;
                w_doneNext   = 1'b0;
                w_opErrNext  = 1'b0;
                w_stateNext  = S_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_A;
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_op     <= 3'd0;
            r_result <= 5'd0;
            r_done   <= 1'b0;
            r_opErr  <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_a      <= w_aNext;
            r_b      <= w_bNext;
            r_op     <= w_opNext;
            r_result <= w_resultNext;
            r_done   <= w_doneNext;
            r_opErr  <= w_opErrNext;
        end
    end

    assign bus.o_a        = r_a;
    assign bus.o_b        = r_b;
    assign bus.o_op       = r_op;
    assign bus.o_result   = r_result;
    assign bus.o_done     = r_done;
    assign bus.o_op_err   = r_opErr;
    assign bus.o_state    = r_state;
endmodule
